// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Event layout, decoder states and well-known scan codes.
package ps2_pkg;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_E0,
        DEC_F0,
        DEC_E0F0
    } dec_state_t;

    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;

    localparam ps2_evt_t KEY_ENTER = '{ext: 1'b0, brk: 1'b0, code: 8'h5A};
    localparam ps2_evt_t KEY_SPACE = '{ext: 1'b0, brk: 1'b0, code: 8'h29};
    localparam ps2_evt_t KEY_BACKSPACE = '{ext: 1'b0, brk: 1'b0, code: 8'h66};
    localparam ps2_evt_t KEY_UP = '{ext: 1'b1, brk: 1'b0, code: 8'h75};
    localparam ps2_evt_t KEY_DOWN = '{ext: 1'b1, brk: 1'b0, code: 8'h72};

endpackage

// File: rtl/ps2_evt_fifo.sv
// Generic event FIFO; full-with-pop accepts the push.
// drop flags a push lost because the FIFO was full.
module ps2_evt_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  T                        din,
    input  logic                    pop,
    output T                        dout,
    output logic                    valid,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign valid   = (level != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && ((level != FULL) || do_pop);
    assign drop    = push && !do_push;
    assign dout    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: oversampled frame capture, E0/F0
// prefix decoding and an event FIFO with sticky overflow.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int TICK_DIV      = 250,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic                         evt_ext,
    output logic                         evt_brk,
    output logic [7:0]                   evt_code,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         ovf,
    input  logic                         clr_ovf,
    output logic                         err_parity,
    output logic                         err_frame,
    output logic                         err_timeout
);
    localparam int DW = $clog2(TICK_DIV);
    localparam int IW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_TICKS - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          ps2c;
    logic          ps2d;
    logic          clk_prev;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          fall;
    logic [10:0]   frame;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] idle_cnt;
    logic          frame_done;
    logic          timeout;
    logic          shape_ok;
    logic          par_ok;
    logic          good;
    logic [7:0]    rx_byte;
    dec_state_t    state;
    dec_state_t    state_nxt;
    logic          emit;
    ps2_evt_t      emit_evt;
    logic          push_q;
    ps2_evt_t      push_evt;
    ps2_evt_t      head;
    logic          drop;

    assign ps2c = clk_sync[1];
    assign ps2d = dat_sync[1];
    assign tick = (div_cnt == DIV_MAX);
    assign fall = tick && clk_prev && !ps2c;

    assign frame_done = (bit_cnt == 4'd11);
    assign timeout = tick && !fall && !frame_done
                   && (bit_cnt != 4'd0) && (idle_cnt == IDLE_LAST);

    assign rx_byte  = frame[8:1];
    assign shape_ok = !frame[0] && frame[10];
    assign par_ok   = ^frame[9:1];
    assign good     = frame_done && shape_ok && par_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
            div_cnt  <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            div_cnt  <= tick ? '0 : div_cnt + 1'b1;
            if (tick) clk_prev <= ps2c;
        end
    end

    // idle_cnt restarts on every captured bit, so it measures line silence
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame    <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
        end else if (frame_done || timeout) begin
            bit_cnt  <= '0;
            idle_cnt <= '0;
        end else if (fall) begin
            frame    <= {ps2d, frame[10:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            idle_cnt <= '0;
        end else if (tick && bit_cnt != 4'd0) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        emit          = 1'b0;
        emit_evt      = '0;
        emit_evt.code = rx_byte;
        if (timeout || (frame_done && !good)) begin
            state_nxt = DEC_IDLE;
        end else if (good) begin
            unique case (state)
                DEC_IDLE: begin
                    if (rx_byte == PS2_E0)      state_nxt = DEC_E0;
                    else if (rx_byte == PS2_F0) state_nxt = DEC_F0;
                    else                        emit = 1'b1;
                end
                DEC_E0: begin
                    if (rx_byte == PS2_F0) begin
                        state_nxt = DEC_E0F0;
                    end else begin
                        emit         = 1'b1;
                        emit_evt.ext = 1'b1;
                        state_nxt    = DEC_IDLE;
                    end
                end
                DEC_F0: begin
                    emit         = 1'b1;
                    emit_evt.brk = 1'b1;
                    state_nxt    = DEC_IDLE;
                end
                DEC_E0F0: begin
                    emit         = 1'b1;
                    emit_evt.ext = 1'b1;
                    emit_evt.brk = 1'b1;
                    state_nxt    = DEC_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= DEC_IDLE;
            push_q      <= 1'b0;
            push_evt    <= '0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_timeout <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            state       <= state_nxt;
            push_q      <= emit;
            push_evt    <= emit_evt;
            err_frame   <= frame_done && !shape_ok;
            err_parity  <= frame_done && shape_ok && !par_ok;
            err_timeout <= timeout;
            if (drop)         ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (ps2_evt_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .din   (push_evt),
        .pop   (evt_ready),
        .dout  (head),
        .valid (evt_valid),
        .level (fifo_level),
        .drop  (drop)
    );

    assign evt_ext  = head.ext;
    assign evt_brk  = head.brk;
    assign evt_code = head.code;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: table vectors, timeout, overflow,
// reset and randomized frames against a prefix-level model.
module tb_ps2_kbd_rx;
    import ps2_pkg::*;

    localparam int TD   = 4;
    localparam int TO   = 40;
    localparam int FD   = 4;
    localparam int HALF = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic evt_ready = 1'b0;
    logic clr_ovf = 1'b0;
    logic evt_valid;
    logic evt_ext;
    logic evt_brk;
    logic [7:0] evt_code;
    logic [$clog2(FD):0] fifo_level;
    logic ovf;
    logic err_parity;
    logic err_frame;
    logic err_timeout;

    ps2_kbd_rx #(
        .TICK_DIV      (TD),
        .TIMEOUT_TICKS (TO),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_ext     (evt_ext),
        .evt_brk     (evt_brk),
        .evt_code    (evt_code),
        .fifo_level  (fifo_level),
        .ovf         (ovf),
        .clr_ovf     (clr_ovf),
        .err_parity  (err_parity),
        .err_frame   (err_frame),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    int n_perr = 0;
    int n_ferr = 0;
    int n_terr = 0;
    bit rnd_rdy = 1'b0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    bit m_ext;
    bit m_brk;
    int x_perr;
    int x_ferr;

    always @(negedge clk) begin
        if (rst) begin
            if (evt_valid && evt_ready)
                got_q.push_back({evt_ext, evt_brk, evt_code});
            if (err_parity)  n_perr++;
            if (err_frame)   n_ferr++;
            if (err_timeout) n_terr++;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_rdy) evt_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_frame(input logic [7:0] code, input bit flip,
                              input bit bstop, input int nbits);
        logic [10:0] fr;
        fr = {~bstop, (~^code) ^ flip, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            wait_clks(HALF);
            ps2_clk = 1'b0;
            wait_clks(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic deliver(input logic [7:0] code, input bit flip,
                           input bit bstop);
        send_frame(code, flip, bstop, 11);
        wait_clks(2 * HALF);
    endtask

    // Prefix bookkeeping with two flags; bad frames forget any prefix
    task automatic model_frame(input logic [7:0] b, input bit flip,
                               input bit bstop);
        if (bstop) begin
            x_ferr++;
            m_ext = 0;
            m_brk = 0;
        end else if (flip) begin
            x_perr++;
            m_ext = 0;
            m_brk = 0;
        end else if (!m_ext && !m_brk && b == 8'hE0) begin
            m_ext = 1;
        end else if (!m_brk && b == 8'hF0) begin
            m_brk = 1;
        end else begin
            exp_q.push_back({m_ext, m_brk, b});
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, evt_valid, 0);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_errs"}, {err_parity, err_frame, err_timeout}, 0);
        check({tag, "_evt"}, {evt_ext, evt_brk, evt_code}, 0);
    endtask

    typedef struct {
        logic [7:0] code;
        bit         flip;
        bit         bstop;
        int         n_evt;
        logic [9:0] evt;
        int         perr;
        int         ferr;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int base;
        int pe;
        int fe;
        int te;
        logic [7:0] mk[5];
        logic [7:0] c;
        int r;

        tbl[0]  = '{8'h1C, 0, 0, 1, 10'h01C, 0, 0};
        tbl[1]  = '{8'hF0, 0, 0, 0, 10'h000, 0, 0};
        tbl[2]  = '{8'h1C, 0, 0, 1, 10'h11C, 0, 0};
        tbl[3]  = '{8'hE0, 0, 0, 0, 10'h000, 0, 0};
        tbl[4]  = '{8'h75, 0, 0, 1, 10'h275, 0, 0};
        tbl[5]  = '{8'hE0, 0, 0, 0, 10'h000, 0, 0};
        tbl[6]  = '{8'hF0, 0, 0, 0, 10'h000, 0, 0};
        tbl[7]  = '{8'h75, 0, 0, 1, 10'h375, 0, 0};
        tbl[8]  = '{8'h5A, 1, 0, 0, 10'h000, 1, 0};
        tbl[9]  = '{8'h5A, 0, 0, 1, 10'h05A, 0, 0};
        tbl[10] = '{8'hE0, 0, 0, 0, 10'h000, 0, 0};
        tbl[11] = '{8'h29, 0, 1, 0, 10'h000, 0, 1};
        tbl[12] = '{8'h72, 0, 0, 1, 10'h072, 0, 0};
        tbl[13] = '{8'hE0, 0, 0, 0, 10'h000, 0, 0};
        tbl[14] = '{8'hE0, 0, 0, 1, 10'h2E0, 0, 0};
        tbl[15] = '{8'hF0, 0, 0, 0, 10'h000, 0, 0};
        tbl[16] = '{8'hF0, 0, 0, 1, 10'h1F0, 0, 0};
        tbl[17] = '{8'h00, 0, 0, 1, 10'h000, 0, 0};

        wait_clks(5);
        check_reset_outputs("por");
        rst = 1'b1;
        wait_clks(5);
        evt_ready = 1'b1;

        foreach (tbl[i]) begin
            base = got_q.size();
            pe = n_perr;
            fe = n_ferr;
            deliver(tbl[i].code, tbl[i].flip, tbl[i].bstop);
            wait_clks(8);
            check($sformatf("tbl%0d_nevt", i), got_q.size() - base,
                  tbl[i].n_evt);
            if (tbl[i].n_evt == 1 && got_q.size() > base)
                check($sformatf("tbl%0d_evt", i), got_q[base], tbl[i].evt);
            check($sformatf("tbl%0d_perr", i), n_perr - pe, tbl[i].perr);
            check($sformatf("tbl%0d_ferr", i), n_ferr - fe, tbl[i].ferr);
            check($sformatf("tbl%0d_level", i), fifo_level, 0);
        end

        te = n_terr;
        send_frame(8'h29, 0, 0, 5);
        wait_clks((TO - 1) * TD - HALF);
        check("tmo_early", n_terr - te, 0);
        wait_clks(8 * TD + HALF);
        check("tmo_pulse", n_terr - te, 1);
        base = got_q.size();
        deliver(8'h29, 0, 0);
        wait_clks(8);
        check("tmo_next_n", got_q.size() - base, 1);
        if (got_q.size() > base) check("tmo_next_evt", got_q[base], 10'h029);

        mk = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        evt_ready = 1'b0;
        foreach (mk[i]) deliver(mk[i], 0, 0);
        check("ovf_level", fifo_level, FD);
        check("ovf_flag", ovf, 1);
        check("ovf_head", {evt_valid, evt_ext, evt_brk, evt_code},
              {3'b100, mk[0]});
        got_q.delete();
        evt_ready = 1'b1;
        wait_clks(10);
        check("drain_n", got_q.size(), FD);
        for (int i = 0; i < FD && i < got_q.size(); i++)
            check($sformatf("drain%0d", i), got_q[i], {2'b00, mk[i]});
        check("drain_level", fifo_level, 0);
        check("ovf_sticky", ovf, 1);
        clr_ovf = 1'b1;
        wait_clks(1);
        clr_ovf = 1'b0;
        wait_clks(1);
        check("ovf_clr", ovf, 0);

        m_ext = 0;
        m_brk = 0;
        x_perr = n_perr;
        x_ferr = n_ferr;
        exp_q.delete();
        got_q.delete();
        rnd_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            c = 8'($urandom_range(0, 255));
            if (r < 2) c = (r == 0) ? 8'hE0 : 8'hF0;
            r = $urandom_range(0, 7);
            deliver(c, r == 0, r == 1);
            model_frame(c, r == 0, r == 1);
            wait_clks($urandom_range(0, 40));
        end
        rnd_rdy = 1'b0;
        evt_ready = 1'b1;
        wait_clks(20);
        check("rnd_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rnd_evt%0d", i), got_q[i], exp_q[i]);
        check("rnd_perr", n_perr, x_perr);
        check("rnd_ferr", n_ferr, x_ferr);

        evt_ready = 1'b0;
        foreach (mk[i]) deliver(mk[i], 0, 0);
        check("pre_rst_level", fifo_level, FD);
        check("pre_rst_ovf", ovf, 1);
        send_frame(8'h3C, 0, 0, 4);
        ps2_clk = 1'b0;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(3);
        check_reset_outputs("rst");
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_clks(2);
        rst = 1'b1;
        pe = n_perr;
        fe = n_ferr;
        te = n_terr;
        wait_clks((TO + 10) * TD);
        check("post_rst_errs", (n_perr - pe) + (n_ferr - fe) + (n_terr - te), 0);
        check("post_rst_level", {evt_valid, fifo_level}, 0);
        got_q.delete();
        evt_ready = 1'b1;
        deliver(8'h3C, 0, 0);
        wait_clks(8);
        check("post_rst_n", got_q.size(), 1);
        if (got_q.size() > 0) check("post_rst_evt", got_q[0], 10'h03C);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter TICK_DIV, default 250: system clocks per sample tick; legal range is 2 or more.
REQ-002 Parameter TIMEOUT_TICKS, default 4000: idle ticks mid-frame before the frame is aborted.
REQ-003 Parameter FIFO_DEPTH, default 8: event FIFO entries; must be a power of 2 and at least 2.
REQ-004 Port list, one per line (name, direction, width, meaning):
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock line; asynchronous to clk.
- ps2_data  in  1  raw PS/2 data line; asynchronous to clk.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head event.
- evt_ext  out  1  head event carried an E0 prefix.
- evt_brk  out  1  head event carried an F0 prefix (key release).
- evt_code  out  8  head event scan code.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- ovf  out  1  sticky: an event was dropped because the FIFO was full.
- clr_ovf  in  1  clears ovf.
- err_parity  out  1  one-clk pulse: frame failed the odd-parity check.
- err_frame  out  1  one-clk pulse: start bit was not 0 or stop bit was not 1.
- err_timeout  out  1  one-clk pulse: frame aborted by timeout.

Function
REQ-005 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser before any use.
REQ-006 A tick SHALL pulse for 1 clk every TICK_DIV clks; the synchronised lines SHALL be sampled only on ticks.
REQ-007 On a tick with a 1->0 transition of synchronised ps2_clk, the current ps2_data SHALL be shifted into the frame register LSB-first, and bit_cnt SHALL increment.
REQ-008 When bit_cnt reaches 11, the frame SHALL be checked within 1 clk and bit_cnt SHALL return to 0. The checks are: start=0, stop=1, and odd parity over data[7:0] plus the parity bit.
REQ-009 Check results SHALL be reported as follows:
- Start or stop bad: err_frame pulses.
- Otherwise, parity bad: err_parity pulses.
- Any failing frame SHALL produce no event and SHALL reset the decoder FSM to IDLE.
REQ-010 While bit_cnt is nonzero, a tick-based idle counter SHALL run. When it reaches TIMEOUT_TICKS, bit_cnt SHALL clear, err_timeout SHALL pulse, and the decoder FSM SHALL go to IDLE.
REQ-011 Each good byte SHALL step the decoder FSM through states IDLE, E0, F0, E0F0 as follows:
- IDLE: byte E0 goes to E0; byte F0 goes to F0; any other byte emits {0,0,byte}.
- E0: byte F0 goes to E0F0; any other byte emits {1,0,byte} and returns to IDLE.
- F0: any byte emits {0,1,byte} and returns to IDLE.
- E0F0: any byte emits {1,1,byte} and returns to IDLE.
REQ-012 An emitted event SHALL be pushed to the FIFO in the clk after the frame check. It SHALL be visible on evt_valid and the evt_* outputs on the following clk.
REQ-013 evt_valid SHALL equal "FIFO not empty", and evt_* SHALL show the head entry. The head SHALL be popped on a clk where evt_valid and evt_ready are both high.
REQ-014 A push when the FIFO is full with no pop in the same clk SHALL be dropped and SHALL set ovf. A push and a pop in the same clk SHALL both succeed, including when the FIFO is full.
REQ-015 ovf SHALL stay set until clr_ovf is high. If clr_ovf and a new drop occur in the same clk, ovf SHALL end that clk set.
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH. fifo_level SHALL be exact from 0 to FIFO_DEPTH.

Reset
REQ-017 While rst is low, the following SHALL hold:
- evt_valid, ovf and all err_* outputs are 0.
- fifo_level is 0.
- evt_ext, evt_brk and evt_code are 0.
- bit_cnt, the tick divider and the idle counter are 0.
- The decoder FSM is in IDLE.
- The synchroniser flops are 1 (idle bus).
REQ-018 Reset asserted mid-frame SHALL discard the partial frame and all FIFO contents, with no error pulse after release.

Structure
REQ-019 Package ps2_pkg SHALL hold the following shared items:
- The event struct {ext, brk, code[7:0]}.
- The decoder state enum.
- The constants PS2_E0=8'hE0 and PS2_F0=8'hF0.
- The key constants ENTER=5A, SPACE=29, BACKSPACE=66, UP=75 (ext), DOWN=72 (ext).
REQ-020 The FIFO SHALL be a separate sub-module, ps2_evt_fifo, parameterised by depth and element type.

Verification
REQ-021 Frame 0x1C (parity 0) with evt_ready=1 -> exactly one event {0,0,1C}, and fifo_level returns to 0.
REQ-022 Frames F0,1C -> one event {0,1,1C}. Frames E0,75 -> {1,0,75}. Frames E0,F0,75 -> {1,1,75}. No events SHALL be emitted for the prefixes themselves.
REQ-023 Frame 0x5A sent with parity bit 0 -> err_parity pulses once and no event is produced. A following valid 0x5A -> {0,0,5A}.
REQ-024 5 bits sent, then the line held idle -> err_timeout pulses after TIMEOUT_TICKS ticks. A following valid frame 0x29 -> {0,0,29}.
REQ-025 FIFO_DEPTH=4, evt_ready=0, 5 make codes sent -> fifo_level=4 and ovf=1. Draining then yields the first 4 codes in order. clr_ovf then clears ovf.
REQ-026 rst pulsed low mid-frame and with a non-empty FIFO -> every output is at its reset value. A following valid frame decodes normally.
